processor_datapath: RTL and testbench
=====================================

// Module: processor_datapath
// PURPOSE
//  Datapath stage driven by the control FSM: instruction register, R0..R7, A and G registers,
//  bus mux, ALU. Consumes sel/op/add_sub_ctrl/load strobes; returns IR_out for decode.
//  Sits downstream of the control FSM and upstream of the top-level register/bus outputs.
// PARAMETERS
//  WIDTH    16   data/bus/register width; IR is always 16 bits; WIDTH >= 16
// PORTS
//  clk           in   1      single clock; all state updates on posedge
//  reset_n       in   1      asynchronous, active-low reset
//  din           in   16     instruction word from upstream; loaded into IR
//  IR_in         in   1      active-low: load IR from din
//  A_in          in   1      active-low: load A from bus
//  G_in          in   1      active-low: load G from ALU result
//  RX_in         in   8      active-low per bit: bit n loads Rn from bus
//  sel           in   4      bus source select
//  op            in   2      ALU op: 00 add/sub, 01 AND, 10/11 pass bus
//  add_sub_ctrl  in   1      0 = add, 1 = subtract (op 00 only)
//  IR_out        out  16     IR contents to control FSM
//  bus           out  WIDTH  current bus value (combinational)
//  r0_out..r7_out out WIDTH  register contents for debug/top level
//  flags         out  3      {N, C, Z}; see CONFIGURATION
// BEHAVIOUR
//  - Reset (async, reset_n low): IR, A, G, R0..R7, flags = 0 immediately; held while low.
//  - Load strobes active-low, sampled at posedge; strobe high = register holds.
//  - Bus mux (combinational): sel 0..7 -> Rn; 8 -> imm = zero-extended IR_out[8:0];
//    9 -> G; 10..15 or any X/Z -> 0.
//  - ALU (combinational, operands A and bus):
//    op 00/ctrl 0: A + bus mod 2^WIDTH; op 00/ctrl 1: A - bus mod 2^WIDTH (two's compl.);
//    op 01: A & bus; op 10/11: bus. X on op -> treated as 10.
//  - G <= ALU result when G_in low. Latency: A load (T1) -> G load (T2) -> Rx via sel 9 (T3).
//  - All loads in one cycle use pre-edge values: Rn with RX_in[n] low and sel = n reloads
//    its own old value; A and G both loading in same cycle use old A.
//  - Multiple RX_in bits low: every selected Rn loads the same bus value.
//  - IR_in low with other strobes: IR updates after edge; bus imm this cycle uses old IR.
//  - Reset asserted mid-instruction: all state clears at once; no partial write survives.
//  - Wrap-around: 16'hFFFF + 1 -> 0; 0 - 1 -> 16'hFFFF.
// CONFIGURATION
//  DATAPATH_FLAGS_EN defined:
//    flags register loads with G (same edge, G_in low):
//    Z = (result == 0); N = result[WIDTH-1];
//    C = carry-out of add / borrow of sub (A < bus unsigned); C = 0 for AND/pass.
//    flags hold when G_in high; reset to 0.
//  DATAPATH_FLAGS_EN undefined: flags port present, tied to 3'b000; no flag logic.
// TESTING
//  1 reset_n low mid-load of R3 = 16'h1234 -> all r*_out, IR_out, flags = 0 before next edge.
//  2 din = 16'h1005, IR_in low; then sel 8, RX_in = 8'hFE -> r0_out = 16'h0005.
//  3 R1 = 7, R2 = 9: A <= R1; op 00/ctrl 1, sel 2, G_in low; sel 9, RX_in[1] low
//    -> r1_out = 16'hFFFE; with FLAGS_EN: flags = {N=1, C=1, Z=0}.
//  4 A = 16'hFFFF, bus = 1, op 00/ctrl 0 -> G = 0; with FLAGS_EN: flags = {0, 1, 1}.
//  5 R4 = 16'h00F0, A = 16'h0F3C, op 01, sel 4 -> G = 16'h0030; RX_in = 8'h00 with sel 9
//    -> all R0..R7 = 16'h0030.
//  6 sel = 4'hC or 4'bxxxx -> bus = 0; RX_in[5] low with sel 5 -> R5 unchanged.

Source files
------------

// File: rtl/processor_datapath.sv
// Datapath stage: IR, R0..R7, A/G registers, bus mux and ALU, all driven by active-low strobes.
// Optional status flags {N, C, Z} are built when DATAPATH_FLAGS_EN is defined; otherwise flags reads 0.
module processor_datapath #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [15:0]      din,
    input  logic             IR_in,
    input  logic             A_in,
    input  logic             G_in,
    input  logic [7:0]       RX_in,
    input  logic [3:0]       sel,
    input  logic [1:0]       op,
    input  logic             add_sub_ctrl,
    output logic [15:0]      IR_out,
    output logic [WIDTH-1:0] bus,
    output logic [WIDTH-1:0] r0_out,
    output logic [WIDTH-1:0] r1_out,
    output logic [WIDTH-1:0] r2_out,
    output logic [WIDTH-1:0] r3_out,
    output logic [WIDTH-1:0] r4_out,
    output logic [WIDTH-1:0] r5_out,
    output logic [WIDTH-1:0] r6_out,
    output logic [WIDTH-1:0] r7_out,
    output logic [2:0]       flags
);

    logic [15:0]      ir_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] g_q;
    logic [WIDTH-1:0] r_q [8];
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] alu_res;

    assign imm = {{(WIDTH-9){1'b0}}, ir_q[8:0]};
    assign sum = a_q + bus;

    // Unlisted or unknown selects fall through to the default so the bus never floats.
    always_comb begin
        bus = '0;
        case (sel)
            4'd0:    bus = r_q[0];
            4'd1:    bus = r_q[1];
            4'd2:    bus = r_q[2];
            4'd3:    bus = r_q[3];
            4'd4:    bus = r_q[4];
            4'd5:    bus = r_q[5];
            4'd6:    bus = r_q[6];
            4'd7:    bus = r_q[7];
            4'd8:    bus = imm;
            4'd9:    bus = g_q;
            default: bus = '0;
        endcase
    end

    always_comb begin
        alu_res = bus;
        case (op)
            2'b00:   alu_res = add_sub_ctrl ? (a_q - bus) : sum;
            2'b01:   alu_res = a_q & bus;
            default: alu_res = bus;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_q <= '0;
            a_q  <= '0;
            g_q  <= '0;
            for (int n = 0; n < 8; n++) r_q[n] <= '0;
        end else begin
            if (!IR_in) ir_q <= din;
            if (!A_in)  a_q  <= bus;
            if (!G_in)  g_q  <= alu_res;
            for (int n = 0; n < 8; n++) begin
                if (!RX_in[n]) r_q[n] <= bus;
            end
        end
    end

`ifdef DATAPATH_FLAGS_EN
    logic       alu_c;
    logic [2:0] flags_q;

    // Subtract reports borrow; an add carried out exactly when the wrapped sum is below A.
    always_comb begin
        alu_c = 1'b0;
        if (op == 2'b00) alu_c = add_sub_ctrl ? (a_q < bus) : (sum < a_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  flags_q <= 3'b000;
        else if (!G_in) flags_q <= {alu_res[WIDTH-1], alu_c, (alu_res == '0)};
    end

    assign flags = flags_q;
`else
    assign flags = 3'b000;
`endif

    assign IR_out = ir_q;
    assign r0_out = r_q[0];
    assign r1_out = r_q[1];
    assign r2_out = r_q[2];
    assign r3_out = r_q[3];
    assign r4_out = r_q[4];
    assign r5_out = r_q[5];
    assign r6_out = r_q[6];
    assign r7_out = r_q[7];

endmodule

// File: tb/tb_processor_datapath.sv
// Bench for processor_datapath: directed register-transfer sequences with literal results,
// then randomized strobes compared every cycle against an arithmetic model of the datapath.
module tb_processor_datapath;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [15:0]  din = '0;
    logic         IR_in = 1'b1;
    logic         A_in = 1'b1;
    logic         G_in = 1'b1;
    logic [7:0]   RX_in = 8'hFF;
    logic [3:0]   sel = '0;
    logic [1:0]   op = 2'b10;
    logic         add_sub_ctrl = 1'b0;
    logic [15:0]  IR_out;
    logic [W-1:0] bus;
    logic [W-1:0] r_out [8];
    logic [2:0]   flags;

    int total = 0;
    int bad = 0;
    bit chk_en = 0;

    processor_datapath #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .din(din), .IR_in(IR_in), .A_in(A_in), .G_in(G_in),
        .RX_in(RX_in), .sel(sel), .op(op), .add_sub_ctrl(add_sub_ctrl),
        .IR_out(IR_out), .bus(bus),
        .r0_out(r_out[0]), .r1_out(r_out[1]), .r2_out(r_out[2]), .r3_out(r_out[3]),
        .r4_out(r_out[4]), .r5_out(r_out[5]), .r6_out(r_out[6]), .r7_out(r_out[7]),
        .flags(flags)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [W-1:0] m_r [8];
    logic [15:0]  m_ir;
    logic [W-1:0] m_a, m_g;
    logic [2:0]   m_flags;
    logic [W-1:0] mb, mres;
    logic         mc;

    function automatic logic [W-1:0] m_bus(input logic [3:0] s);
        if (s < 4'd8) return m_r[s[2:0]];
        if (s == 4'd8) return W'(m_ir & 16'h01FF);
        if (s == 4'd9) return m_g;
        return '0;
    endfunction

    task automatic m_alu(input logic [1:0] o, input logic c, input logic [W-1:0] a,
                         input logic [W-1:0] b, output logic [W-1:0] res, output logic carry);
        longint unsigned modv = 64'd1 << W;
        longint unsigned av = 64'(a);
        longint unsigned bv = 64'(b);
        if (o == 2'b00 && !c) begin
            res = W'((av + bv) % modv);
            carry = (av + bv) >= modv;
        end else if (o == 2'b00) begin
            res = W'((av + modv - bv) % modv);
            carry = av < bv;
        end else if (o == 2'b01) begin
            res = a & b;
            carry = 1'b0;
        end else begin
            res = b;
            carry = 1'b0;
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_ir = '0; m_a = '0; m_g = '0; m_flags = '0;
            for (int n = 0; n < 8; n++) m_r[n] = '0;
        end else begin
            mb = m_bus(sel);
            m_alu(op, add_sub_ctrl, m_a, mb, mres, mc);
            if (!G_in) begin
                m_g = mres;
                m_flags = {mres[W-1], mc, (mres == '0)};
            end
            if (!A_in) m_a = mb;
            for (int n = 0; n < 8; n++) if (!RX_in[n]) m_r[n] = mb;
            if (!IR_in) m_ir = din;
        end
    end

    function automatic logic [2:0] exp_flags(input logic [2:0] f);
`ifdef DATAPATH_FLAGS_EN
        return f;
`else
        return 3'b000 & f;
`endif
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("ir_out", W'(IR_out), W'(m_ir));
            check("bus", bus, m_bus(sel));
            for (int n = 0; n < 8; n++) check($sformatf("r%0d_out", n), r_out[n], m_r[n]);
            check("flags", W'(flags), W'(exp_flags(m_flags)));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        IR_in = 1'b1; A_in = 1'b1; G_in = 1'b1; RX_in = 8'hFF;
    endtask

    task automatic drive(input logic ir_n, input logic a_n, input logic g_n, input logic [7:0] rx,
                         input logic [3:0] s, input logic [1:0] o, input logic c);
        IR_in = ir_n; A_in = a_n; G_in = g_n; RX_in = rx; sel = s; op = o; add_sub_ctrl = c;
        tick();
        idle();
    endtask

    task automatic load_ir(input logic [15:0] v);
        din = v;
        drive(1'b0, 1'b1, 1'b1, 8'hFF, 4'd0, 2'b10, 1'b0);
    endtask

    // Builds any 16-bit value in G from 9-bit immediates by repeated doubling.
    task automatic make_g(input logic [15:0] val);
        logic [15:0] hi, lo;
        hi = val >> 9;
        lo = val & 16'h01FF;
        load_ir(16'h0000);
        drive(1'b1, 1'b0, 1'b1, 8'hFF, 4'd8, 2'b10, 1'b0);
        load_ir(hi);
        drive(1'b1, 1'b1, 1'b0, 8'hFF, 4'd8, 2'b00, 1'b0);
        repeat (9) begin
            drive(1'b1, 1'b0, 1'b1, 8'hFF, 4'd9, 2'b10, 1'b0);
            drive(1'b1, 1'b1, 1'b0, 8'hFF, 4'd9, 2'b00, 1'b0);
        end
        load_ir(lo);
        drive(1'b1, 1'b0, 1'b1, 8'hFF, 4'd9, 2'b10, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 8'hFF, 4'd8, 2'b00, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (2) tick();
        for (int n = 0; n < 8; n++) check("reset_r", r_out[n], '0);
        check("reset_ir", W'(IR_out), '0);
        check("reset_flags", W'(flags), '0);
        reset_n = 1'b1;
        chk_en = 1;
        tick();

        // Immediate load into R0
        load_ir(16'h1005);
        check("ir_load", W'(IR_out), 16'h1005);
        drive(1'b1, 1'b1, 1'b1, 8'hFE, 4'd8, 2'b10, 1'b0);
        check("imm_to_r0", r_out[0], 16'h0005);

        // 7 - 9 wraps negative with borrow
        load_ir(16'd7);
        drive(1'b1, 1'b1, 1'b1, 8'hFD, 4'd8, 2'b10, 1'b0);
        load_ir(16'd9);
        drive(1'b1, 1'b1, 1'b1, 8'hFB, 4'd8, 2'b10, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 8'hFF, 4'd1, 2'b10, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 8'hFF, 4'd2, 2'b00, 1'b1);
`ifdef DATAPATH_FLAGS_EN
        check("sub_flags", W'(flags), W'(3'b110));
`else
        check("sub_flags", W'(flags), W'(3'b000));
`endif
        drive(1'b1, 1'b1, 1'b1, 8'hFD, 4'd9, 2'b10, 1'b0);
        check("sub_result_r1", r_out[1], 16'hFFFE);

        // FFFF + 1 wraps to zero with carry
        make_g(16'hFFFF);
        sel = 4'd9;
        #1 check("make_g_ffff", bus, 16'hFFFF);
        drive(1'b1, 1'b0, 1'b1, 8'hFF, 4'd9, 2'b10, 1'b0);
        load_ir(16'd1);
        drive(1'b1, 1'b1, 1'b0, 8'hFF, 4'd8, 2'b00, 1'b0);
`ifdef DATAPATH_FLAGS_EN
        check("add_flags", W'(flags), W'(3'b011));
`else
        check("add_flags", W'(flags), W'(3'b000));
`endif
        sel = 4'd9;
        #1 check("add_wrap_g", bus, 16'h0000);

        // AND then broadcast to all registers
        load_ir(16'h00F0);
        drive(1'b1, 1'b1, 1'b1, 8'hEF, 4'd8, 2'b10, 1'b0);
        make_g(16'h0F3C);
        drive(1'b1, 1'b0, 1'b1, 8'hFF, 4'd9, 2'b10, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 8'hFF, 4'd4, 2'b01, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 8'h00, 4'd9, 2'b10, 1'b0);
        for (int n = 0; n < 8; n++) check("and_broadcast", r_out[n], 16'h0030);

        // Unused selects and self-reload
        sel = 4'hC;
        #1 check("sel_c_bus", bus, '0);
        sel = 4'hF;
        #1 check("sel_f_bus", bus, '0);
        drive(1'b1, 1'b1, 1'b1, 8'hDF, 4'd5, 2'b10, 1'b0);
        check("r5_self_reload", r_out[5], 16'h0030);

        // Asynchronous reset in the middle of an R3 load
        make_g(16'h1234);
        sel = 4'd9;
        RX_in = 8'hF7;
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_r3", r_out[3], '0);
        check("async_rst_ir", W'(IR_out), '0);
        check("async_rst_flags", W'(flags), '0);
        check("async_rst_bus", bus, '0);
        tick();
        check("rst_held_r3", r_out[3], '0);
        idle();
        reset_n = 1'b1;
        tick();

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            din = 16'($urandom);
            IR_in = ($urandom_range(0, 3) != 0);
            A_in = 1'($urandom_range(0, 1));
            G_in = 1'($urandom_range(0, 1));
            RX_in = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom_range(0, 255));
            sel = 4'($urandom_range(0, 15));
            op = 2'($urandom_range(0, 3));
            add_sub_ctrl = 1'($urandom_range(0, 1));
            if (i % 200 == 100) begin
                #2 reset_n = 1'b0;
                tick();
                reset_n = 1'b1;
            end else begin
                tick();
            end
        end

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
